// File: rtl/vga_rx_decoder.sv
// Receive-side VGA timing decoder: rebuilds x/y/de from hsync/vsync/rgb, measures
// line/frame geometry, tracks lock and captures rgb at one programmable pixel.
module vga_rx_decoder #(
    parameter int   H_ACTIVE    = 640,
    parameter int   H_BP        = 48,
    parameter int   V_ACTIVE    = 480,
    parameter int   V_BP        = 33,
    parameter logic SYNC_ACT    = 1'b0,
    parameter int   LOCK_FRAMES = 2,
    parameter int   H_TIMEOUT   = 2048
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [11:0] rgb,
    input  logic [9:0]  cap_x,
    input  logic [9:0]  cap_y,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        de,
    output logic [11:0] rgb_out,
    output logic        frame_start,
    output logic [11:0] line_len,
    output logic [10:0] frame_lines,
    output logic        locked,
    output logic [11:0] cap_rgb,
    output logic        cap_valid
);

    localparam logic [11:0] H_LO   = 12'(H_BP);
    localparam logic [11:0] H_HI   = 12'(H_BP + H_ACTIVE);
    localparam logic [10:0] V_LO   = 11'(V_BP);
    localparam logic [10:0] V_HI   = 11'(V_BP + V_ACTIVE);
    localparam logic [11:0] TO_LIM = 12'(H_TIMEOUT);
    localparam logic [3:0]  LF     = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

    logic        hs_q, hs_p_q, vs_q, vs_p_q;
    logic [11:0] rgb1_q, rgb2_q;
    logic [11:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic [11:0] ll_cnt_q, ll_cnt_d, line_len_q, line_len_d;
    logic [10:0] fl_cnt_q, fl_cnt_d, frame_lines_q, frame_lines_d, fl_now;
    state_t      state_q, state_d;
    logic [11:0] ref_ll_q, ref_ll_d;
    logic [10:0] ref_fl_q, ref_fl_d;
    logic [3:0]  match_q, match_d;
    logic        skip_q, skip_d;
    logic [9:0]  x_q, y_q, x_d, y_d, h_off, v_off;
    logic        de_q, de_next, hit;
    logic [11:0] rgb_out_q, cap_rgb_q;
    logic        frame_start_q, cap_valid_q;
    logic        hs_lead, hs_trail, vs_lead, vs_trail, timeout, geom_same;

    always_comb begin
        hs_lead  = (hs_q == SYNC_ACT) && (hs_p_q != SYNC_ACT);
        hs_trail = (hs_q != SYNC_ACT) && (hs_p_q == SYNC_ACT);
        vs_lead  = (vs_q == SYNC_ACT) && (vs_p_q != SYNC_ACT);
        vs_trail = (vs_q != SYNC_ACT) && (vs_p_q == SYNC_ACT);

        h_cnt_d = hs_trail ? 12'd0 : (&h_cnt_q ? h_cnt_q : h_cnt_q + 12'd1);
        v_cnt_d = v_cnt_q;
        if (vs_trail)
            v_cnt_d = 11'd0;
        else if (hs_trail && !(&v_cnt_q))
            v_cnt_d = v_cnt_q + 11'd1;

        // A line whose hsync edge coincides with the vsync edge belongs to the ending frame
        ll_cnt_d      = hs_lead ? 12'd1 : (&ll_cnt_q ? ll_cnt_q : ll_cnt_q + 12'd1);
        fl_now        = (hs_lead && !(&fl_cnt_q)) ? fl_cnt_q + 11'd1 : fl_cnt_q;
        fl_cnt_d      = vs_lead ? 11'd0 : fl_now;
        timeout       = !hs_lead && (ll_cnt_q >= TO_LIM);
        line_len_d    = timeout ? 12'd0 : (hs_lead ? ll_cnt_q : line_len_q);
        frame_lines_d = vs_lead ? fl_now : frame_lines_q;
        geom_same     = (line_len_d == ref_ll_q) && (frame_lines_d == ref_fl_q);

        de_next = (h_cnt_q >= H_LO) && (h_cnt_q < H_HI) && (v_cnt_q >= V_LO) && (v_cnt_q < V_HI);
        h_off   = 10'(h_cnt_q - H_LO);
        v_off   = 10'(v_cnt_q - V_LO);
        x_d     = de_next ? h_off : x_q;
        y_d     = de_next ? v_off : y_q;
        hit     = de_next && (h_off == cap_x) && (v_off == cap_y);
    end

    always_comb begin
        state_d  = state_q;
        ref_ll_d = ref_ll_q;
        ref_fl_d = ref_fl_q;
        match_d  = match_q;
        skip_d   = skip_q;
        if (timeout) begin
            state_d = SEARCH;
        end else begin
            case (state_q)
                SEARCH: if (vs_lead) begin
                    // The frame ending at the first vsync after reset is partial
                    if (skip_q) begin
                        skip_d = 1'b0;
                    end else begin
                        ref_ll_d = line_len_d;
                        ref_fl_d = frame_lines_d;
                        match_d  = 4'd1;
                        state_d  = (LF <= 4'd1) ? LOCKED : TRACK;
                    end
                end
                TRACK: if (vs_lead) begin
                    if (geom_same) begin
                        match_d = match_q + 4'd1;
                        if (match_q + 4'd1 >= LF)
                            state_d = LOCKED;
                    end else begin
                        ref_ll_d = line_len_d;
                        ref_fl_d = frame_lines_d;
                        match_d  = 4'd1;
                    end
                end
                LOCKED: begin
                    if ((vs_lead && !geom_same) || (hs_lead && (ll_cnt_q != ref_ll_q)))
                        state_d = SEARCH;
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_q          <= ~SYNC_ACT;
            hs_p_q        <= ~SYNC_ACT;
            vs_q          <= ~SYNC_ACT;
            vs_p_q        <= ~SYNC_ACT;
            rgb1_q        <= '0;
            rgb2_q        <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            ll_cnt_q      <= '0;
            fl_cnt_q      <= '0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            state_q       <= SEARCH;
            ref_ll_q      <= '0;
            ref_fl_q      <= '0;
            match_q       <= '0;
            skip_q        <= 1'b1;
            x_q           <= '0;
            y_q           <= '0;
            de_q          <= 1'b0;
            rgb_out_q     <= '0;
            cap_rgb_q     <= '0;
            frame_start_q <= 1'b0;
            cap_valid_q   <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            cap_valid_q   <= 1'b0;
            if (pix_en) begin
                hs_q          <= hsync;
                hs_p_q        <= hs_q;
                vs_q          <= vsync;
                vs_p_q        <= vs_q;
                rgb1_q        <= rgb;
                // Counters lag the input register by one tick, so rgb needs one more stage
                rgb2_q        <= rgb1_q;
                h_cnt_q       <= h_cnt_d;
                v_cnt_q       <= v_cnt_d;
                ll_cnt_q      <= ll_cnt_d;
                fl_cnt_q      <= fl_cnt_d;
                line_len_q    <= line_len_d;
                frame_lines_q <= frame_lines_d;
                frame_start_q <= vs_lead;
                state_q       <= state_d;
                ref_ll_q      <= ref_ll_d;
                ref_fl_q      <= ref_fl_d;
                match_q       <= match_d;
                skip_q        <= skip_d;
                x_q           <= x_d;
                y_q           <= y_d;
                de_q          <= de_next;
                rgb_out_q     <= rgb2_q;
                cap_valid_q   <= hit;
                if (hit)
                    cap_rgb_q <= rgb2_q;
            end
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign de          = de_q;
    assign rgb_out     = rgb_out_q;
    assign frame_start = frame_start_q;
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
    assign locked      = (state_q == LOCKED);
    assign cap_rgb     = cap_rgb_q;
    assign cap_valid   = cap_valid_q;

endmodule

// File: tb/tb_vga_rx_decoder.sv
// Directed bench for vga_rx_decoder on a reduced 25x14 raster (16x8 active),
// with a probe table for decoded pixels and hand sequences for lock corner cases.
module tb_vga_rx_decoder;

    // Raster: hc 0..15 active, 16..17 FP, 18..20 hsync, 21..24 BP
    //         ln 0..7 active, 8 FP, 9..10 vsync, 11..13 BP
    localparam int HT = 25;
    localparam int VT = 14;

    logic        clk = 1'b0;
    logic        reset, pix_en, hsync, vsync;
    logic [11:0] rgb;
    logic [9:0]  cap_x, cap_y;
    logic [9:0]  x, y;
    logic        de, frame_start, locked, cap_valid;
    logic [11:0] rgb_out, line_len, cap_rgb;
    logic [10:0] frame_lines;

    vga_rx_decoder #(
        .H_ACTIVE(16), .H_BP(4), .V_ACTIVE(8), .V_BP(3),
        .SYNC_ACT(1'b0), .LOCK_FRAMES(2), .H_TIMEOUT(64)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
        .rgb(rgb), .cap_x(cap_x), .cap_y(cap_y), .x(x), .y(y), .de(de),
        .rgb_out(rgb_out), .frame_start(frame_start), .line_len(line_len),
        .frame_lines(frame_lines), .locked(locked), .cap_rgb(cap_rgb),
        .cap_valid(cap_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ln;
        int          hc;
        logic        de;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [11:0] rgb;
        logic        cv;
    } vec_t;

    vec_t tbl [9];
    int   checks = 0, failures = 0;
    int   frm = 0, ln = 0, hc = 0;
    int   a0 = -1, a1 = -1, a2 = -1;
    int   de_cnt = 0, cv_cnt = 0, fs_cnt = 0;
    bit   tbl_en = 1'b0, hs_kill = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        hsync = hs_kill ? 1'b1 : !(hc >= 18 && hc < 21);
        vsync = !(ln >= 9 && ln < 11);
        rgb   = (hc < 16 && ln < 8) ? {6'(ln), 6'(hc)} : 12'h000;
    endtask

    // One pixel tick; outputs seen afterwards belong to the position two ticks back
    task automatic step(input bit hold);
        drive();
        pix_en = 1'b1;
        @(posedge clk);
        #1;
        a2 = a1; a1 = a0; a0 = ln * 100 + hc;
        if (de)          de_cnt++;
        if (cap_valid)   cv_cnt++;
        if (frame_start) fs_cnt++;
        if (tbl_en)
            for (int i = 0; i < 9; i++)
                if (a2 == tbl[i].ln * 100 + tbl[i].hc)
                    chk($sformatf("vec%0d", i), {de, x, y, rgb_out, cap_valid},
                        {tbl[i].de, tbl[i].x, tbl[i].y, tbl[i].rgb, tbl[i].cv});
        if (!hold) begin
            hc++;
            if (hc == HT) begin
                hc = 0; ln++;
                if (ln == VT) begin ln = 0; frm++; end
            end
        end
    endtask

    task automatic run_to(input int f, input int l, input int h);
        int guard = 0;
        while (!(frm == f && ln == l && hc == h)) begin
            step(1'b0);
            guard++;
            if (guard > 20000) begin
                failures++;
                $display("FAIL run_to: position %0d/%0d/%0d not reached", f, l, h);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $fatal(1, "stimulus lost");
            end
        end
    endtask

    initial begin
        int bad;
        tbl[0] = '{0,  0,  1'b1, 10'd0,  10'd0, 12'h000, 1'b0};
        tbl[1] = '{0,  15, 1'b1, 10'd15, 10'd0, 12'h00F, 1'b0};
        tbl[2] = '{0,  16, 1'b0, 10'd15, 10'd0, 12'h000, 1'b0};
        tbl[3] = '{3,  5,  1'b1, 10'd5,  10'd3, 12'h0C5, 1'b0};
        tbl[4] = '{5,  20, 1'b0, 10'd15, 10'd5, 12'h000, 1'b0};
        tbl[5] = '{7,  0,  1'b1, 10'd0,  10'd7, 12'h1C0, 1'b0};
        tbl[6] = '{7,  15, 1'b1, 10'd15, 10'd7, 12'h1CF, 1'b1};
        tbl[7] = '{8,  0,  1'b0, 10'd15, 10'd7, 12'h000, 1'b0};
        tbl[8] = '{12, 3,  1'b0, 10'd15, 10'd7, 12'h000, 1'b0};

        cap_x = 10'd15; cap_y = 10'd7;
        reset = 1'b1; pix_en = 1'b1; hsync = 1'b1; vsync = 1'b1; rgb = '0;

        // Reset held with random sync/rgb
        bad = 0;
        repeat (20) begin
            hsync = 1'($urandom); vsync = 1'($urandom); rgb = 12'($urandom);
            @(posedge clk); #1;
            if (de || locked || cap_valid || frame_start) bad++;
        end
        chk("reset_quiet", 64'(bad), 64'd0);
        chk("reset_outs_a", {x, y, rgb_out, line_len}, 64'd0);
        chk("reset_outs_b", {frame_lines, cap_rgb, de, locked}, 64'd0);
        reset = 1'b0;

        // Lock on the third vsync leading edge after reset
        run_to(1, 9, 1); step(1'b0);
        chk("lock_not_second", 64'(locked), 64'd0);
        run_to(2, 9, 0); step(1'b0);
        chk("lock_early", 64'(locked), 64'd0);
        step(1'b0);
        chk("lock_third", {locked, frame_start, line_len, frame_lines},
            {1'b1, 1'b1, 12'd25, 11'd14});

        // Full frame with pixel probes
        de_cnt = 0; cv_cnt = 0; fs_cnt = 0; tbl_en = 1'b1;
        run_to(4, 0, 0);
        tbl_en = 1'b0;
        chk("de_per_frame", 64'(de_cnt), 64'd128);
        chk("cap_per_frame", 64'(cv_cnt), 64'd1);
        chk("fs_per_frame", 64'(fs_cnt), 64'd1);
        chk("cap_rgb", 64'(cap_rgb), 64'h1CF);

        // Line 1 of frame 4 stretched to 26 ticks
        run_to(4, 1, 16); step(1'b1);
        run_to(4, 1, 18); step(1'b0);
        chk("stretch_prelock", 64'(locked), 64'd1);
        step(1'b0);
        chk("stretch_unlock", {locked, line_len}, {1'b0, 12'd26});

        // pix_en low: everything holds
        run_to(4, 5, 7); step(1'b0);
        bad = 0;
        pix_en = 1'b0;
        repeat (4) begin
            rgb = 12'($urandom); hsync = 1'($urandom); vsync = 1'($urandom);
            @(posedge clk); #1;
            if (frame_start || cap_valid) bad++;
        end
        chk("stall_hold", {de, x, y, rgb_out, 8'(bad)},
            {1'b1, 10'd5, 10'd5, 12'h145, 8'd0});

        run_to(4, 9, 1); step(1'b0);
        chk("relock_early", 64'(locked), 64'd0);
        run_to(5, 9, 1); step(1'b0);
        chk("relock", 64'(locked), 64'd1);

        // hsync suppressed: last lead at (5,13,18), limit 64 ticks
        run_to(6, 0, 0);
        hs_kill = 1'b1;
        run_to(6, 2, 7); step(1'b0);
        chk("timeout_minus1", {locked, line_len}, {1'b1, 12'd25});
        step(1'b0);
        chk("timeout", {locked, line_len}, {1'b0, 12'd0});
        run_to(6, 3, 0);
        hs_kill = 1'b0;

        // Reset mid-line at y=3
        run_to(7, 3, 8);
        reset = 1'b1;
        step(1'b0);
        reset = 1'b0;
        chk("midreset_a", {x, y, de, locked, frame_start, cap_valid}, 64'd0);
        chk("midreset_b", {rgb_out, line_len, frame_lines, cap_rgb}, 64'd0);
        run_to(8, 9, 1); step(1'b0);
        chk("midreset_wait", 64'(locked), 64'd0);
        run_to(9, 9, 1); step(1'b0);
        chk("midreset_relock", 64'(locked), 64'd1);

        // Capture point moved at the start of a frame takes effect in that frame
        run_to(10, 0, 0);
        cap_x = 10'd5; cap_y = 10'd3;
        cv_cnt = 0;
        run_to(11, 0, 0);
        chk("cap_live", {cap_rgb, 8'(cv_cnt)}, {12'h0C5, 8'd1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
